hough_vote_engine: RTL

- Parametrised successor to the single-point Hough coordinate transform.
- For one edge pixel (x,y), sweeps a programmable theta window [theta_lo..theta_hi] with a programmable stride and computes rho = x·cos θ + y·sin θ against an external cos/sin ROM.
- Emits one (theta, rho-bin) vote per cycle on a valid/ready stream to the accumulator RAM writer.
- Keeps the start/done handshake; adds backpressure, range/stride selection, saturation flag and vote count.

---
 rtl/hough_vote_engine.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/hough_vote_engine.sv
// hough_vote_engine
// Sweeps theta over [theta_lo..theta_hi] with a programmable stride for one
// edge pixel (x,y) and emits one (theta, rho-bin) vote per cycle on a
// valid/ready stream. rho = x*cos + y*sin, rounded, offset by 2^(RHO_WIDTH-1)
// and clamped to the bin range.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   start                 one-cycle request, sampled only when idle
//   x_in, y_in            pixel coordinates, latched on accepted start
//   theta_lo/hi/stride    sweep window and increment (stride 0 acts as 1)
//   trig_addr             ROM address; trig_cos/trig_sin return one cycle later
//   vote_valid/ready      vote stream handshake
//   vote_theta/rho/last   vote payload; last marks the final issued theta
//   busy, done            busy from accepted start to completion; done pulse
//   vote_count, sat_flag  accepted votes and sticky clamp flag for the point
//
// States
//   S_IDLE   | waiting for start
//   S_ISSUE  | issuing ROM addresses, one per enabled cycle
//   S_DRAIN  | all addresses issued, waiting for the last vote to be accepted
//   S_FINISH | done pulse, back to idle
module hough_vote_engine #(
    parameter int X_WIDTH     = 10,
    parameter int Y_WIDTH     = 10,
    parameter int THETA_WIDTH = 8,
    parameter int TRIG_FRAC   = 14,
    parameter int RHO_WIDTH   = 11
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [X_WIDTH-1:0]            x_in,
    input  logic [Y_WIDTH-1:0]            y_in,
    input  logic [THETA_WIDTH-1:0]        theta_lo,
    input  logic [THETA_WIDTH-1:0]        theta_hi,
    input  logic [THETA_WIDTH-1:0]        theta_stride,
    output logic [THETA_WIDTH-1:0]        trig_addr,
    input  logic signed [TRIG_FRAC+1:0]   trig_cos,
    input  logic signed [TRIG_FRAC+1:0]   trig_sin,
    output logic                          vote_valid,
    input  logic                          vote_ready,
    output logic [THETA_WIDTH-1:0]        vote_theta,
    output logic [RHO_WIDTH-1:0]          vote_rho,
    output logic                          vote_last,
    output logic                          busy,
    output logic                          done,
    output logic [THETA_WIDTH:0]          vote_count,
    output logic                          sat_flag
);

    localparam int TW  = TRIG_FRAC + 2;
    localparam int XYW = (X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH;
    localparam int PW  = XYW + TRIG_FRAC + 3;
    localparam int SW  = PW + 1;
    localparam logic signed [SW-1:0] RND  = SW'(2 ** (TRIG_FRAC - 1));
    localparam logic signed [SW-1:0] OFS  = SW'(2 ** (RHO_WIDTH - 1));
    localparam logic signed [SW-1:0] RMAX = SW'(2 ** RHO_WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FINISH} state_t;

    state_t                   state_q, state_d;
    logic [THETA_WIDTH-1:0]   addr_q, addr_d;
    logic [X_WIDTH-1:0]       x_q;
    logic [Y_WIDTH-1:0]       y_q;
    logic [THETA_WIDTH-1:0]   hi_q, stride_q;
    logic                     latch;

    logic                     en, en_prev_q;
    logic signed [TW-1:0]     cos_hold_q, sin_hold_q, cos_sel, sin_sel;
    logic                     s2_valid_q, s2_last_q, s3_valid_q, s3_last_q;
    logic [THETA_WIDTH-1:0]   s2_theta_q, s3_theta_q;
    logic signed [PW-1:0]     px_q, py_q, px_d, py_d;
    logic signed [SW-1:0]     sum, biased;
    logic [RHO_WIDTH-1:0]     rho_d;
    logic                     clamp;

    logic                     vote_valid_q, vote_last_q, sat_q;
    logic [THETA_WIDTH-1:0]   vote_theta_q;
    logic [RHO_WIDTH-1:0]     vote_rho_q;
    logic [THETA_WIDTH:0]     vote_count_q;

    logic [THETA_WIDTH:0]     addr_next;
    logic                     issue_last;
    logic                     accept;

    assign en      = !(vote_valid_q && !vote_ready);
    assign accept  = vote_valid_q && vote_ready;

    // One extra bit so a step past the top of the theta range is seen as
    // "beyond theta_hi" instead of wrapping back into the window.
    assign addr_next  = {1'b0, addr_q} + {1'b0, stride_q};
    assign issue_last = addr_next > {1'b0, hi_q};

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        latch   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    latch = 1'b1;
                    if (theta_lo > theta_hi) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_ISSUE;
                        addr_d  = theta_lo;
                    end
                end
            end
            S_ISSUE: begin
                if (en) begin
                    if (issue_last) state_d = S_DRAIN;
                    else            addr_d  = addr_next[THETA_WIDTH-1:0];
                end
            end
            S_DRAIN: begin
                if (accept && vote_last_q) state_d = S_FINISH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            x_q      <= '0;
            y_q      <= '0;
            hi_q     <= '0;
            stride_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            if (latch) begin
                x_q      <= x_in;
                y_q      <= y_in;
                hi_q     <= theta_hi;
                stride_q <= (theta_stride == '0) ? THETA_WIDTH'(1) : theta_stride;
            end
        end
    end

    // The ROM keeps clocking its held address during a stall, so after the
    // first stalled cycle its output belongs to stage 1, not stage 2. Keep
    // the stage-2 data captured while it was still current and use it on
    // the cycle the stall releases.
    assign cos_sel = en_prev_q ? trig_cos : cos_hold_q;
    assign sin_sel = en_prev_q ? trig_sin : sin_hold_q;

    always_comb begin
        px_d = PW'($signed({1'b0, x_q})) * PW'(cos_sel);
        py_d = PW'($signed({1'b0, y_q})) * PW'(sin_sel);
    end

    always_comb begin
        sum    = SW'(px_q) + SW'(py_q) + RND;
        biased = (sum >>> TRIG_FRAC) + OFS;
        clamp  = 1'b0;
        rho_d  = biased[RHO_WIDTH-1:0];
        if (biased[SW-1]) begin
            rho_d = '0;
            clamp = 1'b1;
        end else if (biased > RMAX) begin
            rho_d = '1;
            clamp = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_prev_q    <= 1'b0;
            cos_hold_q   <= '0;
            sin_hold_q   <= '0;
            s2_valid_q   <= 1'b0;
            s2_last_q    <= 1'b0;
            s2_theta_q   <= '0;
            s3_valid_q   <= 1'b0;
            s3_last_q    <= 1'b0;
            s3_theta_q   <= '0;
            px_q         <= '0;
            py_q         <= '0;
            vote_valid_q <= 1'b0;
            vote_last_q  <= 1'b0;
            vote_theta_q <= '0;
            vote_rho_q   <= '0;
        end else begin
            en_prev_q <= en;
            if (en_prev_q) begin
                cos_hold_q <= trig_cos;
                sin_hold_q <= trig_sin;
            end
            if (en) begin
                s2_valid_q   <= (state_q == S_ISSUE);
                s2_last_q    <= issue_last;
                s2_theta_q   <= addr_q;
                s3_valid_q   <= s2_valid_q;
                s3_last_q    <= s2_last_q;
                s3_theta_q   <= s2_theta_q;
                px_q         <= px_d;
                py_q         <= py_d;
                vote_valid_q <= s3_valid_q;
                vote_last_q  <= s3_last_q;
                vote_theta_q <= s3_theta_q;
                vote_rho_q   <= rho_d;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vote_count_q <= '0;
            sat_q        <= 1'b0;
        end else if (latch) begin
            vote_count_q <= '0;
            sat_q        <= 1'b0;
        end else begin
            if (accept) vote_count_q <= vote_count_q + (THETA_WIDTH+1)'(1);
            if (en && s3_valid_q && clamp) sat_q <= 1'b1;
        end
    end

    assign trig_addr  = addr_q;
    assign vote_valid = vote_valid_q;
    assign vote_theta = vote_theta_q;
    assign vote_rho   = vote_rho_q;
    assign vote_last  = vote_last_q;
    assign vote_count = vote_count_q;
    assign sat_flag   = sat_q;
    assign busy       = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done       = (state_q == S_FINISH);

endmodule
